// File: rtl/digit_entry_pkg.sv
// Shared key codes, state encoding and helpers for the keypad digit-entry buffer.
package digit_entry_pkg;

  localparam logic [3:0] KEY_BKSP  = 4'hA;
  localparam logic [3:0] KEY_CLR   = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_SIGN  = 4'hF;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_FULL   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Key codes 0-9 are decimal digits; everything above is a command or unused.
  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_shift_reg.sv
// Packed BCD nibble register. New digits enter at nibble 0 and push older ones up;
// shr drops the newest digit and zero-fills from the top. The caller guarantees
// shl_in is only issued below capacity and shr only when count is non-zero.
module bcd_shift_reg #(
  parameter int NUM_DIGITS = 5,
  localparam int CNT_W = $clog2(NUM_DIGITS + 1),
  localparam int W     = 4 * NUM_DIGITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             shl_in,
  input  logic             shr,
  input  logic [3:0]       digit,
  output logic [W-1:0]     value,
  output logic [CNT_W-1:0] count
);

  // Clear has priority; shift-in and shift-right are never requested together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value <= '0;
      count <= '0;
    end else if (clr) begin
      value <= '0;
      count <= '0;
    end else if (shl_in) begin
      value <= {value[W-5:0], digit};
      count <= count + 1'b1;
    end else if (shr) begin
      value <= {4'h0, value[W-1:4]};
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/digit_entry_buffer.sv
// Keypad digit-entry buffer: builds a signed BCD number one key at a time and
// hands it downstream over a valid/ready commit port.
//
//   state     | meaning
//   ----------+----------------------------------------------------
//   ST_EMPTY  | no digits held, sign forced positive
//   ST_ENTRY  | 0 < count < NUM_DIGITS, digits/sign editable
//   ST_FULL   | count == NUM_DIGITS, further digits ignored
//   ST_COMMIT | committed number held until downstream takes it
module digit_entry_buffer
  import digit_entry_pkg::*;
#(
  parameter int NUM_DIGITS      = 5,
  parameter bit ALLOW_LEAD_ZERO = 1'b0,
  localparam int CNT_W = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [3:0]              key,
  input  logic                    key_valid,
  output logic                    key_ready,
  output logic [4*NUM_DIGITS-1:0] display,
  output logic [CNT_W-1:0]        count,
  output logic                    neg,
  output logic                    full,
  output logic                    commit_valid,
  input  logic                    commit_ready,
  output logic [4*NUM_DIGITS-1:0] commit_value,
  output logic                    commit_neg
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t state_q, state_d;
  logic   neg_q, neg_d;
  logic   key_fire;
  logic   shl_in, shr, clr, commit_load;

  bcd_shift_reg #(.NUM_DIGITS(NUM_DIGITS)) u_digits (
    .clock  (clock),
    .reset  (reset),
    .clr    (clr),
    .shl_in (shl_in),
    .shr    (shr),
    .digit  (key),
    .value  (display),
    .count  (count)
  );

  assign key_ready    = (state_q != ST_COMMIT);
  assign key_fire     = key_valid && key_ready;
  assign commit_valid = (state_q == ST_COMMIT);
  assign full         = (count == CNT_FULL);
  assign neg          = neg_q;

  // State, sign and committed-number registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      neg_q        <= 1'b0;
      commit_value <= '0;
      commit_neg   <= 1'b0;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      if (commit_load) begin
        commit_value <= display;
        commit_neg   <= neg_q;
      end
    end
  end

  // Key decode: next state plus shift-register and commit controls.
  always_comb begin
    state_d     = state_q;
    neg_d       = neg_q;
    shl_in      = 1'b0;
    shr         = 1'b0;
    clr         = 1'b0;
    commit_load = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        // Only a digit can leave EMPTY; a leading zero is dropped unless allowed.
        if (key_fire && is_digit(key) && ((key != 4'd0) || ALLOW_LEAD_ZERO)) begin
          shl_in  = 1'b1;
          state_d = ST_ENTRY;
        end
      end
      ST_ENTRY, ST_FULL: begin
        if (key_fire) begin
          if (is_digit(key)) begin
            if (state_q == ST_ENTRY) begin
              shl_in = 1'b1;
              if (count == CNT_LAST) state_d = ST_FULL;
            end
          end else begin
            case (key)
              KEY_BKSP: begin
                shr = 1'b1;
                if (count == CNT_ONE) begin
                  state_d = ST_EMPTY;
                  neg_d   = 1'b0;
                end else begin
                  state_d = ST_ENTRY;
                end
              end
              KEY_CLR: begin
                clr     = 1'b1;
                neg_d   = 1'b0;
                state_d = ST_EMPTY;
              end
              KEY_SIGN: neg_d = ~neg_q;
              KEY_ENTER: begin
                commit_load = 1'b1;
                clr         = 1'b1;
                neg_d       = 1'b0;
                state_d     = ST_COMMIT;
              end
              default: ;
            endcase
          end
        end
      end
      ST_COMMIT: begin
        if (commit_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

endmodule

// File: tb/tb_digit_entry_buffer.sv
// Self-checking bench for digit_entry_buffer (NUM_DIGITS=5, no leading zeros).
module tb_digit_entry_buffer;

  localparam int N = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_ready;
  logic [19:0] display;
  logic [2:0]  count;
  logic        neg;
  logic        full;
  logic        commit_valid;
  logic        commit_ready;
  logic [19:0] commit_value;
  logic        commit_neg;

  int checks = 0;
  int failures = 0;

  digit_entry_buffer #(.NUM_DIGITS(N), .ALLOW_LEAD_ZERO(1'b0)) dut (
    .clock        (clock),
    .reset        (reset),
    .key          (key),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .display      (display),
    .count        (count),
    .neg          (neg),
    .full         (full),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .commit_value (commit_value),
    .commit_neg   (commit_neg)
  );

  always #5 clock = ~clock;

  // Behavioural reference: digits held as a list, most significant first.
  int          m_digits[$];
  logic        m_neg;
  logic        m_pending;
  logic [19:0] m_cval;
  logic        m_cneg;

  function automatic logic [19:0] m_bcd();
    logic [19:0] r = '0;
    int sz = m_digits.size();
    for (int i = 0; i < sz; i++) r[4*i +: 4] = 4'(m_digits[sz-1-i]);
    return r;
  endfunction

  function automatic void m_reset();
    m_digits.delete();
    m_neg = 1'b0; m_pending = 1'b0; m_cval = '0; m_cneg = 1'b0;
  endfunction

  function automatic void m_step(logic [3:0] k, logic kv, logic cr);
    if (m_pending) begin
      if (cr) m_pending = 1'b0;
    end else if (kv) begin
      if (k <= 4'd9) begin
        if (!(m_digits.size() == 0 && k == 4'd0) && m_digits.size() < N)
          m_digits.push_back(int'(k));
      end else if (k == 4'hA) begin
        if (m_digits.size() > 0) void'(m_digits.pop_back());
        if (m_digits.size() == 0) m_neg = 1'b0;
      end else if (k == 4'hB) begin
        m_digits.delete(); m_neg = 1'b0;
      end else if (k == 4'hF) begin
        if (m_digits.size() > 0) m_neg = ~m_neg;
      end else if (k == 4'hE) begin
        if (m_digits.size() > 0) begin
          m_cval = m_bcd(); m_cneg = m_neg; m_pending = 1'b1;
          m_digits.delete(); m_neg = 1'b0;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, step the model at the same edge, then sample #1 later.
  task automatic drive(input logic [3:0] k, input logic kv, input logic cr);
    key = k; key_valid = kv; commit_ready = cr;
    @(posedge clock);
    m_step(k, kv, cr);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".display"},   32'(display),      32'(m_bcd()));
    chk({tag, ".count"},     32'(count),        32'(m_digits.size()));
    chk({tag, ".neg"},       32'(neg),          32'(m_neg));
    chk({tag, ".full"},      32'(full),         32'(m_digits.size() == N));
    chk({tag, ".key_ready"}, 32'(key_ready),    32'(!m_pending));
    chk({tag, ".cvalid"},    32'(commit_valid), 32'(m_pending));
    chk({tag, ".cvalue"},    32'(commit_value), 32'(m_cval));
    chk({tag, ".cneg"},      32'(commit_neg),   32'(m_cneg));
  endtask

  typedef struct {
    logic [3:0]  key;
    logic [19:0] disp;
    logic [2:0]  cnt;
    logic        neg;
    logic        full;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(logic [3:0] k, logic [19:0] d, logic [2:0] c, logic n, logic f);
    vec_t v;
    v.key = k; v.disp = d; v.cnt = c; v.neg = n; v.full = f;
    vecs.push_back(v);
  endfunction

  initial begin
    reset = 1'b1; key = '0; key_valid = 1'b0; commit_ready = 1'b0;
    m_reset();
    #12 reset = 1'b0;

    chk("reset.display", 32'(display), 32'h0);
    chk("reset.count", 32'(count), 32'h0);
    chk("reset.cvalid", 32'(commit_valid), 32'h0);
    chk("reset.key_ready", 32'(key_ready), 32'h1);

    addv(4'h1, 20'h00001, 3'd1, 1'b0, 1'b0);
    addv(4'h2, 20'h00012, 3'd2, 1'b0, 1'b0);
    addv(4'h3, 20'h00123, 3'd3, 1'b0, 1'b0);
    addv(4'hB, 20'h00000, 3'd0, 1'b0, 1'b0);
    addv(4'h0, 20'h00000, 3'd0, 1'b0, 1'b0);
    addv(4'h0, 20'h00000, 3'd0, 1'b0, 1'b0);
    addv(4'h7, 20'h00007, 3'd1, 1'b0, 1'b0);
    addv(4'hB, 20'h00000, 3'd0, 1'b0, 1'b0);
    addv(4'h9, 20'h00009, 3'd1, 1'b0, 1'b0);
    addv(4'h8, 20'h00098, 3'd2, 1'b0, 1'b0);
    addv(4'h7, 20'h00987, 3'd3, 1'b0, 1'b0);
    addv(4'h6, 20'h09876, 3'd4, 1'b0, 1'b0);
    addv(4'h5, 20'h98765, 3'd5, 1'b0, 1'b1);
    addv(4'h4, 20'h98765, 3'd5, 1'b0, 1'b1);
    addv(4'hF, 20'h98765, 3'd5, 1'b1, 1'b1);
    addv(4'hA, 20'h09876, 3'd4, 1'b1, 1'b0);
    addv(4'hB, 20'h00000, 3'd0, 1'b0, 1'b0);
    addv(4'hF, 20'h00000, 3'd0, 1'b0, 1'b0);
    addv(4'h4, 20'h00004, 3'd1, 1'b0, 1'b0);
    addv(4'hF, 20'h00004, 3'd1, 1'b1, 1'b0);
    addv(4'hA, 20'h00000, 3'd0, 1'b0, 1'b0);
    addv(4'hA, 20'h00000, 3'd0, 1'b0, 1'b0);
    addv(4'hE, 20'h00000, 3'd0, 1'b0, 1'b0);
    addv(4'h3, 20'h00003, 3'd1, 1'b0, 1'b0);
    addv(4'hC, 20'h00003, 3'd1, 1'b0, 1'b0);
    addv(4'hD, 20'h00003, 3'd1, 1'b0, 1'b0);
    addv(4'hB, 20'h00000, 3'd0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].key, 1'b1, 1'b0);
      chk($sformatf("vec%0d.display", i), 32'(display), 32'(vecs[i].disp));
      chk($sformatf("vec%0d.count", i),   32'(count),   32'(vecs[i].cnt));
      chk($sformatf("vec%0d.neg", i),     32'(neg),     32'(vecs[i].neg));
      chk($sformatf("vec%0d.full", i),    32'(full),    32'(vecs[i].full));
      chk($sformatf("vec%0d.cvalid", i),  32'(commit_valid), 32'h0);
    end

    // Commit with a stalled downstream, then release it.
    drive(4'h4, 1'b1, 1'b0);
    drive(4'h2, 1'b1, 1'b0);
    drive(4'hF, 1'b1, 1'b0);
    drive(4'hE, 1'b1, 1'b0);
    chk("commit.cvalid", 32'(commit_valid), 32'h1);
    chk("commit.cvalue", 32'(commit_value), 32'h00042);
    chk("commit.cneg", 32'(commit_neg), 32'h1);
    chk("commit.key_ready", 32'(key_ready), 32'h0);
    chk("commit.display", 32'(display), 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(4'h5, 1'b1, 1'b0);
      chk($sformatf("stall%0d.cvalid", i), 32'(commit_valid), 32'h1);
      chk($sformatf("stall%0d.count", i), 32'(count), 32'h0);
      chk($sformatf("stall%0d.cvalue", i), 32'(commit_value), 32'h00042);
    end
    drive(4'h0, 1'b0, 1'b1);
    chk("release.cvalid", 32'(commit_valid), 32'h0);
    chk("release.key_ready", 32'(key_ready), 32'h1);
    chk("release.display", 32'(display), 32'h0);
    chk("release.cvalue_kept", 32'(commit_value), 32'h00042);
    chk("release.cneg_kept", 32'(commit_neg), 32'h1);
    drive(4'h6, 1'b1, 1'b0);
    chk("after_release.display", 32'(display), 32'h00006);

    // Asynchronous reset while a commit is pending.
    drive(4'hE, 1'b1, 1'b0);
    chk("precommit.cvalid", 32'(commit_valid), 32'h1);
    reset = 1'b1;
    #1;
    m_reset();
    chk("async.cvalid", 32'(commit_valid), 32'h0);
    chk("async.cvalue", 32'(commit_value), 32'h0);
    chk("async.cneg", 32'(commit_neg), 32'h0);
    chk("async.key_ready", 32'(key_ready), 32'h1);
    chk("async.display", 32'(display), 32'h0);
    #2 reset = 1'b0;

    // Randomised traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] k;
      // Favour digits so the buffer regularly fills up.
      k = ($urandom_range(0, 2) != 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      drive(k, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
      chk_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
